boot_loader_ctrl: RTL and testbench

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_loader_ctrl_pkg.sv | 20 ++
 rtl/boot_loader_ctrl_timeout_counter.sv | 41 ++++
 rtl/boot_loader_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_ctrl_pkg.sv
// Shared SoC definitions for the serial boot loader: FSM encoding and frame constants.
package boot_loader_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        CNT_LO    = 3'd1,
        CNT_HI    = 3'd2,
        DATA      = 3'd3,
        CHECK     = 3'd4,
        RUN       = 3'd5,
        ERROR     = 3'd6
    } bl_state_e;

    localparam logic [7:0] BL_SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic is_busy_state(input bl_state_e s);
        return (s inside {CNT_LO, CNT_HI, DATA, CHECK});
    endfunction

endpackage

// File: rtl/boot_loader_ctrl_timeout_counter.sv
// Up-counting timeout: counts while load_i is high, flags expire_o on the cycle it sits at LIMIT.
module timeout_counter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LIMIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic load_i,
    output logic expire_o
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins over advance.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = load_i && !clear_i && (count_q == LIMIT_W);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Serial boot loader between the UART receiver and the instruction-memory write port.
// The SoC holds the CPU in reset with (system reset OR cpu_reset).
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ          = 27000000,
    parameter int unsigned MEMORY_SIZE         = 2048,
    parameter int unsigned BOOT_WINDOW_CYCLES  = 27000000,
    parameter int unsigned BYTE_TIMEOUT_CYCLES = 270000,
    parameter logic [7:0]  SYNC_BYTE           = BL_SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Timers are wide enough for either timeout or one second of cycles, whichever is larger.
    localparam int unsigned TMR_MAX = (BOOT_WINDOW_CYCLES > BYTE_TIMEOUT_CYCLES)
        ? ((BOOT_WINDOW_CYCLES > CLOCK_FREQ) ? BOOT_WINDOW_CYCLES : CLOCK_FREQ)
        : ((BYTE_TIMEOUT_CYCLES > CLOCK_FREQ) ? BYTE_TIMEOUT_CYCLES : CLOCK_FREQ);
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
    localparam logic [16:0] MAX_WORDS = 17'(MEMORY_SIZE / 4);

    bl_state_e   state_q, state_d;
    logic        win_act_q, win_act_d;
    logic [7:0]  cnt_lo_q, cnt_lo_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  chk_byte_q, chk_byte_d;
    logic        chk_got_q, chk_got_d;
    logic        wr_pend_q, wr_pend_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, done_q, error_q, cpu_reset_q;

    logic in_frame;
    logic pend_after;
    logic win_expire;
    logic byte_expire;

    assign in_frame   = is_busy_state(state_q);
    assign pend_after = wr_pend_q && !mem_ready;

    timeout_counter #(.WIDTH(TMR_W), .LIMIT(BOOT_WINDOW_CYCLES - 1)) u_boot_window (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (!win_act_q),
        .load_i   (win_act_q && (state_q == WAIT_SYNC)),
        .expire_o (win_expire)
    );

    // Byte timer freezes once the checksum byte is held waiting for the last write.
    timeout_counter #(.WIDTH(TMR_W), .LIMIT(BYTE_TIMEOUT_CYCLES - 1)) u_byte_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (rx_valid || !in_frame),
        .load_i   (in_frame && !rx_valid && !chk_got_q),
        .expire_o (byte_expire)
    );

    // Frame parser, write-holding register and checksum decision.
    always_comb begin
        state_d    = state_q;
        cnt_lo_d   = cnt_lo_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        chk_byte_d = chk_byte_q;
        chk_got_d  = chk_got_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_pend_d  = wr_pend_q && !mem_ready;

        case (state_q)
            WAIT_SYNC, ERROR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d    = CNT_LO;
                    csum_d     = 8'h00;
                    byte_idx_d = 2'd0;
                    word_idx_d = 16'd0;
                    chk_got_d  = 1'b0;
                end else if (rx_valid && (state_q == ERROR)) begin
                    state_d = WAIT_SYNC;
                end else if (win_expire) begin
                    state_d = RUN;
                end else begin
                    state_d = state_q;
                end
            end
            CNT_LO: begin
                if (rx_valid) begin
                    cnt_lo_d = rx_data;
                    state_d  = CNT_HI;
                end else if (byte_expire) begin
                    state_d = ERROR;
                end else begin
                    state_d = CNT_LO;
                end
            end
            CNT_HI: begin
                if (rx_valid) begin
                    count_d = {rx_data, cnt_lo_q};
                    if ({1'b0, rx_data, cnt_lo_q} > MAX_WORDS) begin
                        state_d = ERROR;
                    end else if ({rx_data, cnt_lo_q} == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end else if (byte_expire) begin
                    state_d = ERROR;
                end else begin
                    state_d = CNT_HI;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q != 2'd3) begin
                        asm_d = {rx_data, asm_q[23:8]};
                    end else if (pend_after) begin
                        state_d = ERROR;
                    end else begin
                        addr_d     = {14'd0, word_idx_q, 2'b00};
                        wdata_d    = {rx_data, asm_q};
                        wr_pend_d  = 1'b1;
                        word_idx_d = word_idx_q + 16'd1;
                        state_d    = (word_idx_q == (count_q - 16'd1)) ? CHECK : DATA;
                    end
                end else if (byte_expire) begin
                    state_d = ERROR;
                end else begin
                    state_d = DATA;
                end
            end
            CHECK: begin
                if (chk_got_q) begin
                    if (!pend_after) begin
                        state_d = (chk_byte_q == csum_q) ? RUN : ERROR;
                    end else begin
                        state_d = CHECK;
                    end
                end else if (rx_valid) begin
                    if (pend_after) begin
                        chk_byte_d = rx_data;
                        chk_got_d  = 1'b1;
                    end else begin
                        state_d = (rx_data == csum_q) ? RUN : ERROR;
                    end
                end else if (byte_expire) begin
                    state_d = ERROR;
                end else begin
                    state_d = CHECK;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = WAIT_SYNC;
            end
        endcase

        // An aborted or finished load never leaves a write in flight.
        if ((state_d == ERROR) || (state_d == RUN)) begin
            wr_pend_d = 1'b0;
        end else begin
            wr_pend_d = wr_pend_d;
        end
        win_act_d = win_act_q && (state_d == WAIT_SYNC);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_SYNC;
            win_act_q   <= 1'b1;
            cnt_lo_q    <= 8'h00;
            count_q     <= 16'd0;
            word_idx_q  <= 16'd0;
            byte_idx_q  <= 2'd0;
            asm_q       <= 24'd0;
            csum_q      <= 8'h00;
            chk_byte_q  <= 8'h00;
            chk_got_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            win_act_q   <= win_act_d;
            cnt_lo_q    <= cnt_lo_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            chk_byte_q  <= chk_byte_d;
            chk_got_q   <= chk_got_d;
            wr_pend_q   <= wr_pend_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= is_busy_state(state_d);
            done_q      <= (state_d == RUN);
            error_q     <= (state_d == ERROR);
            cpu_reset_q <= (state_d != RUN);
        end
    end

    assign mem_we    = wr_pend_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: boot window, valid/bad frames, size limit, overrun, timeout, reset.
module tb_boot_loader_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int base;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    always #5 clk = ~clk;

    boot_loader_ctrl #(
        .CLOCK_FREQ          (1000),
        .MEMORY_SIZE         (2048),
        .BOOT_WINDOW_CYCLES  (100),
        .BYTE_TIMEOUT_CYCLES (50),
        .SYNC_BYTE           (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // Log every accepted memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1 && mem_ready === 1'b1) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cs);
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(cs);
    endtask

    initial begin
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        mem_ready = 1'b1;

        // Reset state, then silent line: boot window expires on cycle 100.
        tick();
        tick();
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_mem_addr",  mem_addr,           32'd0);
        check("rst_mem_wdata", mem_wdata,          32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_error",     {31'd0, error},     32'd0);
        reset = 1'b0;
        base  = wr_cnt;
        repeat (99) tick();
        check("win_done_c99",  {31'd0, done},      32'd0);
        tick();
        check("win_done_c100", {31'd0, done},      32'd1);
        check("win_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("win_writes",    wr_cnt - base,      32'd0);
        send(8'hA5);
        check("run_ignores_rx", {31'd0, busy},     32'd0);
        check("run_no_we",      {31'd0, mem_we},   32'd0);

        // Valid two-word frame; checksum is 0x13 ^ 0x93 ^ 0x10 = 0x90.
        do_reset();
        base = wr_cnt;
        send_frame(8'h90);
        check("ok_done",      {31'd0, done},      32'd1);
        check("ok_error",     {31'd0, error},     32'd0);
        check("ok_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("ok_busy",      {31'd0, busy},      32'd0);
        check("ok_nwrites",   wr_cnt - base,      32'd2);
        check("ok_addr0",     wr_addr[base],      32'h0000_0000);
        check("ok_data0",     wr_data[base],      32'h0000_0013);
        check("ok_addr1",     wr_addr[base + 1],  32'h0000_0004);
        check("ok_data1",     wr_data[base + 1],  32'h0010_0093);

        // Bad checksum, then recovery by resending from ERROR.
        do_reset();
        send_frame(8'h81);
        check("bad_error",     {31'd0, error},     32'd1);
        check("bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("bad_done",      {31'd0, done},      32'd0);
        check("bad_busy",      {31'd0, busy},      32'd0);
        send_frame(8'h90);
        check("retry_done",    {31'd0, done},      32'd1);
        check("retry_error",   {31'd0, error},     32'd0);

        // Count 0x0201 exceeds 512 words; then a non-sync byte parks in WAIT_SYNC with no window.
        do_reset();
        base = wr_cnt;
        send(8'hA5); send(8'h01); send(8'h02);
        check("big_error",    {31'd0, error},  32'd1);
        check("big_no_we",    {31'd0, mem_we}, 32'd0);
        send(8'h00);
        check("err_to_wait_error", {31'd0, error}, 32'd0);
        check("err_to_wait_busy",  {31'd0, busy},  32'd0);
        repeat (150) tick();
        check("no_second_window", {31'd0, done}, 32'd0);
        send(8'hA5); send(8'h00); send(8'h00);
        check("zero_cnt_busy", {31'd0, busy}, 32'd1);
        send(8'h00);
        check("zero_cnt_done", {31'd0, done}, 32'd1);
        check("big_writes",    wr_cnt - base, 32'd0);

        // Overrun: memory stalls, bytes every 10 cycles, second word completes while first pending.
        do_reset();
        base      = wr_cnt;
        mem_ready = 1'b0;
        send(8'hA5); send(8'h04); send(8'h00);
        send(8'h11); repeat (9) tick();
        send(8'h22); repeat (9) tick();
        send(8'h33); repeat (9) tick();
        send(8'h44);
        check("ovr_we_first",   {31'd0, mem_we}, 32'd1);
        check("ovr_addr",       mem_addr,        32'h0000_0000);
        check("ovr_wdata",      mem_wdata,       32'h4433_2211);
        repeat (9) tick();
        check("ovr_we_held",    {31'd0, mem_we}, 32'd1);
        check("ovr_wdata_held", mem_wdata,       32'h4433_2211);
        send(8'h55); repeat (9) tick();
        send(8'h66); repeat (9) tick();
        send(8'h77); repeat (9) tick();
        check("ovr_no_error_yet", {31'd0, error}, 32'd0);
        send(8'h88);
        check("ovr_error",   {31'd0, error},  32'd1);
        check("ovr_we_drop", {31'd0, mem_we}, 32'd0);
        check("ovr_writes",  wr_cnt - base,   32'd0);
        mem_ready = 1'b1;

        // Byte timeout mid-DATA: error lands exactly 50 idle cycles after the last byte.
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00); send(8'h01); send(8'h02);
        repeat (49) tick();
        check("to_error_c49", {31'd0, error}, 32'd0);
        check("to_busy_c49",  {31'd0, busy},  32'd1);
        tick();
        check("to_error_c50", {31'd0, error}, 32'd1);

        // Reset mid-frame drops the pending write.
        do_reset();
        mem_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        check("mid_we_pending", {31'd0, mem_we}, 32'd1);
        check("mid_busy",       {31'd0, busy},   32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_we",        {31'd0, mem_we},    32'd0);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        reset     = 1'b0;
        mem_ready = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
